fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_INSTR, default 32'h0000_0013, value held on if_instr when no valid instruction (NOP).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pc_in  input  32  current PC from the PC register.
REQ-005 npc  output  32  next-PC value to the PC register.
REQ-006 pc_we  output  1  PC register write enable; PC loads npc on the edge where pc_we=1.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_ready  input  1  memory accepts request when valid&ready.
REQ-009 imem_req_addr  output  32  request address, equal to pc_in.
REQ-010 imem_rsp_valid  input  1  read data valid, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 redirect_valid  input  1  branch/jump taken from EX.
REQ-013 redirect_target  input  32  redirect destination.
REQ-014 stall_id  input  1  decode cannot consume if_* this cycle.
REQ-015 if_valid  output  1  IF/ID register holds a valid instruction.
REQ-016 if_pc  output  32  PC of instruction in IF/ID register.
REQ-017 if_instr  output  32  instruction in IF/ID register.

Function
REQ-018 At most one memory request outstanding; FSM states IDLE, WAIT, HOLD, DROP; registered state.
REQ-019 Consume: ID takes if_* in any cycle with if_valid=1 and stall_id=0; IF/ID register loadable when if_valid=0 or stall_id=0.
REQ-020 IDLE: imem_req_valid=1 iff redirect_valid=0; on acceptance, latch req_pc=pc_in, pc_we=1, npc=pc_in+4 (mod 2^32, 32'hFFFF_FFFC -> 0), go WAIT.
REQ-021 IDLE without acceptance: pc_we=0 (unless redirect), stay IDLE.
REQ-022 WAIT, rsp_valid, IF/ID loadable: if_valid<=1, if_pc<=req_pc, if_instr<=imem_rsp_data, go IDLE.
REQ-023 WAIT, rsp_valid, IF/ID not loadable: capture data and req_pc in skid buffer, go HOLD.
REQ-024 HOLD: no request issued; when IF/ID loadable, move skid buffer into IF/ID (if_valid<=1), go IDLE.
REQ-025 Redirect (highest priority, any state): pc_we=1, npc={redirect_target[31:2],2'b00}; if_valid<=0 next cycle regardless of stall_id; skid buffer discarded.
REQ-026 Redirect next state: IDLE->IDLE; HOLD->IDLE; WAIT without rsp_valid->DROP; WAIT with rsp_valid->IDLE (response discarded); DROP->DROP, or IDLE if rsp_valid same cycle.
REQ-027 DROP: no request issued; on rsp_valid discard data, IF/ID unchanged, go IDLE.
REQ-028 IF/ID register, when not loaded and not flushed: if consumed, if_valid<=0; else hold all if_* values.
REQ-029 pc_we=0 and npc=pc_in+4 whenever no acceptance and no redirect in that cycle.
REQ-030 imem_req_addr=pc_in always; imem_req_valid=0 in WAIT, HOLD, DROP.

Reset
REQ-031 rst=1 asynchronously forces state IDLE, if_valid=0, if_pc=0, if_instr=RESET_INSTR, skid buffer cleared; outputs valid during reset: pc_we=0, imem_req_valid=0.
REQ-032 Reset mid-transaction abandons the outstanding request; an imem_rsp_valid arriving after reset release with no accepted request SHALL be ignored.
REQ-033 First request issued in the first cycle after rst deasserts, with imem_req_addr=pc_in (0x0000_0000 after PC reset).

Verification
REQ-034 Streaming: pc_in=0x0, ready=1, rsp 1 cycle later, stall_id=0 -> if_pc sequence 0x0,0x4,0x8, one instruction per 2 cycles, pc_we pulses on each acceptance.
REQ-035 Backpressure: rsp_valid for pc 0x10 while if_valid=1 and stall_id=1 -> HOLD; release stall 3 cycles later -> if_pc=0x10 next cycle, no request issued during HOLD.
REQ-036 Redirect in WAIT: request 0x20 accepted, redirect_target=0x103 next cycle -> npc=0x100, pc_we=1, state DROP; rsp for 0x20 discarded; next request addr 0x100.
REQ-037 Simultaneous rsp_valid and redirect in WAIT -> response dropped, if_valid=0, state IDLE, next request addr = target.
REQ-038 Wrap: pc_in=0xFFFF_FFFC accepted -> npc=0x0000_0000, pc_we=1.
REQ-039 Async reset asserted in WAIT mid-cycle -> if_valid=0 and imem_req_valid=0 immediately; late rsp after release ignored, if_instr=0x0000_0013.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch controller with one outstanding request,
//            a one-entry skid buffer and redirect/flush handling.
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall_id,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_req_pc;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic        w_req_valid;
    logic        w_accept;
    logic        w_loadable;
    logic        w_load_rsp;
    logic        w_load_skid;
    logic        w_skid_we;

    assign w_loadable = !r_if_valid || !stall_id;

    always_comb begin
        w_next      = r_state;
        w_req_valid = 1'b0;
        w_load_rsp  = 1'b0;
        w_load_skid = 1'b0;
        w_skid_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_valid = !redirect_valid;
                if (!redirect_valid && imem_req_ready)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_next = imem_rsp_valid ? S_IDLE : S_DROP;
                end else if (imem_rsp_valid) begin
                    if (w_loadable) begin
                        w_load_rsp = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_skid_we  = 1'b1;
                        w_next     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_next = S_IDLE;
                end else if (w_loadable) begin
                    w_load_skid = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid)
                    w_next = S_IDLE;
            end
        endcase
    end

    // Reset gates the handshake outputs combinationally so they are quiet
    // for the whole reset window, not just after the next edge.
    assign imem_req_valid = w_req_valid && !rst;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign pc_we          = !rst && (redirect_valid || w_accept);
    assign npc            = redirect_valid ? (redirect_target & 32'hFFFF_FFFC)
                                           : (pc_in + 32'd4);
    assign imem_req_addr  = pc_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_pc     <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= RESET_INSTR;
        end else begin
            if (w_accept)
                r_req_pc <= pc_in;
            if (w_skid_we) begin
                r_skid_pc    <= r_req_pc;
                r_skid_instr <= imem_rsp_data;
            end
        end
    end

    // A flush only invalidates; the stale pc/instr stay put until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_instr <= RESET_INSTR;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
        end else if (w_load_rsp) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_req_pc;
            r_if_instr <= imem_rsp_data;
        end else if (w_load_skid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_skid_pc;
            r_if_instr <= r_skid_instr;
        end else if (r_if_valid && !stall_id) begin
            r_if_valid <= 1'b0;
        end
    end

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed plus randomized bench for fetch_ctrl against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] npc;
    logic        pc_we;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall_id;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int checks   = 0;
    int failures = 0;

    // Reference model: PC register, outstanding request, held response, IF/ID
    logic [31:0] pc_reg;
    logic        o_valid, o_drop;
    logic [31:0] o_pc;
    logic        h_valid;
    logic [31:0] h_pc, h_data;
    logic        m_ifv;
    logic [31:0] m_ifpc, m_ifinstr;
    logic        last_acc;

    // Memory responder used by the random phase
    logic        mem_busy;
    int          mem_cnt;

    fetch_ctrl #(.RESET_INSTR(C_NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .npc             (npc),
        .pc_we           (pc_we),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall_id        (stall_id),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pc_reg    = 32'd0;
        o_valid   = 1'b0;
        o_drop    = 1'b0;
        o_pc      = 32'd0;
        h_valid   = 1'b0;
        h_pc      = 32'd0;
        h_data    = 32'd0;
        m_ifv     = 1'b0;
        m_ifpc    = 32'd0;
        m_ifinstr = C_NOP;
        last_acc  = 1'b0;
        mem_busy  = 1'b0;
        mem_cnt   = 0;
    endtask

    // One clock cycle: called and returns 1 time unit after a rising edge.
    task automatic cyc(input logic rdy, input logic rsp, input logic [31:0] data,
                       input logic redir, input logic [31:0] tgt, input logic stall);
        logic        e_req, acc, e_we, consumed, loadable;
        logic [31:0] e_npc;
        pc_in           = pc_reg;
        imem_req_ready  = rdy;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = data;
        redirect_valid  = redir;
        redirect_target = tgt;
        stall_id        = stall;

        e_req = !(o_valid || h_valid) && !redir;
        acc   = e_req && rdy;
        e_we  = redir || acc;
        e_npc = redir ? (tgt & ~32'd3) : pc_reg + 32'd4;
        #2;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
        chk("req_addr", imem_req_addr, pc_reg);
        chk("pc_we", {31'd0, pc_we}, {31'd0, e_we});
        chk("npc", npc, e_npc);

        @(posedge clk);
        consumed = m_ifv && !stall;
        loadable = !m_ifv || !stall;
        if (redir) begin
            m_ifv   = 1'b0;
            h_valid = 1'b0;
            if (o_valid) begin
                if (rsp) o_valid = 1'b0;
                else     o_drop  = 1'b1;
            end
        end else if (rsp && o_valid) begin
            o_valid = 1'b0;
            if (o_drop) begin
                if (consumed) m_ifv = 1'b0;
            end else if (loadable) begin
                m_ifv = 1'b1; m_ifpc = o_pc; m_ifinstr = data;
            end else begin
                h_valid = 1'b1; h_pc = o_pc; h_data = data;
            end
        end else if (h_valid && loadable) begin
            m_ifv = 1'b1; m_ifpc = h_pc; m_ifinstr = h_data;
            h_valid = 1'b0;
        end else if (consumed) begin
            m_ifv = 1'b0;
        end
        if (acc) begin
            o_valid = 1'b1; o_drop = 1'b0; o_pc = pc_reg;
        end
        if (e_we) pc_reg = e_npc;
        last_acc = acc;
        #1;
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_ifv});
        chk("if_pc", if_pc, m_ifpc);
        chk("if_instr", if_instr, m_ifinstr);
    endtask

    // Cycle whose response comes from the bench's memory responder.
    task automatic rand_cycle(input logic rdy, input logic redir, input logic [31:0] tgt,
                              input logic stall);
        logic rsp;
        rsp = mem_busy && (mem_cnt == 0);
        cyc(rdy, rsp, $urandom, redir, tgt, stall);
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (last_acc) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(0, 2);
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_in = 32'd0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0; redirect_valid = 1'b0; redirect_target = 32'd0;
        stall_id = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, C_NOP);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b0;

        // Streaming: one instruction per two cycles from address 0
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            cyc(1'b0, 1'b1, $urandom, 1'b0, 32'd0, 1'b0);
            chk("stream_if_pc", if_pc, 32'(i * 4));
        end

        // Backpressure into the skid buffer
        pc_reg = 32'h10;
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, $urandom, 1'b0, 32'd0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("hold_if_pc", if_pc, 32'h10);

        // Redirect while waiting: late response dropped
        pc_reg = 32'h20;
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h103, 1'b0);
        chk("redir_pc", pc_reg, 32'h100);
        cyc(1'b1, 1'b1, $urandom, 1'b0, 32'd0, 1'b0);
        chk("drop_if_valid", {31'd0, if_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, $urandom, 1'b0, 32'd0, 1'b0);
        chk("after_drop_if_pc", if_pc, 32'h100);

        // Response and redirect in the same cycle
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, $urandom, 1'b1, 32'h200, 1'b0);
        chk("simul_if_valid", {31'd0, if_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, $urandom, 1'b0, 32'd0, 1'b0);
        chk("simul_if_pc", if_pc, 32'h200);

        // Address wrap
        pc_reg = 32'hFFFF_FFFC;
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("wrap_pc", pc_reg, 32'h0);
        cyc(1'b0, 1'b1, $urandom, 1'b0, 32'd0, 1'b0);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rand_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                       $urandom, $urandom_range(0, 2) == 0);
        end
        repeat (6) rand_cycle(1'b0, 1'b0, 32'd0, 1'b0);

        // Asynchronous reset while a request is outstanding
        pc_reg = 32'h40;
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("arst_pc_we", {31'd0, pc_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 1'b1, $urandom, 1'b0, 32'd0, 1'b0);
        chk("late_rsp_if_instr", if_instr, C_NOP);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
        chk("post_rst_instr", if_instr, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
